// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - fetch request handshake between pc_unit and instruction memory
interface pc_unit_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;

    modport master (
        output fetch_valid,
        output pc,
        output pc_plus4,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  pc,
        input  pc_plus4,
        output fetch_ready
    );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC with redirect/trap arbitration, halt/resume and fetch counter
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              CNT_W        = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             trap_valid_i,
    input  logic             trap_ret_i,
    input  logic             halt_req_i,
    input  logic             resume_i,
    pc_unit_if.master        fetch,
    output logic [XLEN-1:0]  epc_o,
    output logic             misaligned_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_cnt_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  epc_q, epc_d;
    logic             mis_q, mis_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign accept = (state_q == ST_RUN) && fetch.fetch_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                // Single winner; a misaligned redirect is turned into a trap entry.
                if (trap_valid_i) begin
                    pc_d  = TRAP_VECTOR;
                    epc_d = pc_q;
                end else if (trap_ret_i) begin
                    pc_d = epc_q;
                end else if (redirect_valid_i) begin
                    if (redirect_target_i[1:0] != 2'b00) begin
                        pc_d  = TRAP_VECTOR;
                        epc_d = pc_q;
                        mis_d = 1'b1;
                    end else begin
                        pc_d = redirect_target_i;
                    end
                end else if (stall_i) begin
                    pc_d = pc_q;
                end else if (accept) begin
                    pc_d = pc_q + XLEN'(4);
                end
                // The handshake counts even when the PC is redirected away this cycle.
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (halt_req_i && !trap_valid_i) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign fetch.fetch_valid = (state_q == ST_RUN);
    assign fetch.pc          = pc_q;
    assign fetch.pc_plus4    = pc_q + XLEN'(4);
    assign epc_o             = epc_q;
    assign misaligned_o      = mis_q;
    assign halted_o          = (state_q == ST_HALT);
    assign fetch_cnt_o       = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit against a behavioural model
module tb_pc_unit;
    localparam int          XLEN  = 32;
    localparam int          CNT_W = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall, redirect_valid, trap_valid, trap_ret, halt_req, resume;
    logic [31:0] redirect_target;
    logic [31:0] epc;
    logic        misaligned, halted;
    logic [31:0] fetch_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    pc_unit_if #(.XLEN(XLEN)) fif ();

    pc_unit #(
        .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .clr(clr),
        .stall_i(stall),
        .redirect_valid_i(redirect_valid),
        .redirect_target_i(redirect_target),
        .trap_valid_i(trap_valid),
        .trap_ret_i(trap_ret),
        .halt_req_i(halt_req),
        .resume_i(resume),
        .fetch(fif.master),
        .epc_o(epc),
        .misaligned_o(misaligned),
        .halted_o(halted),
        .fetch_cnt_o(fetch_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model of the architectural state.
    logic [31:0] m_pc, m_epc, m_cnt;
    bit          m_halt, m_mis;

    always @(posedge clk) begin
        logic [31:0] npc;
        if (!clr) begin
            m_pc = RV; m_epc = 0; m_cnt = 0; m_halt = 0; m_mis = 0;
        end else if (m_halt) begin
            m_mis = 0;
            if (resume) m_halt = 0;
        end else begin
            npc   = m_pc;
            m_mis = 0;
            if (trap_valid) begin
                npc = TV; m_epc = m_pc;
            end else if (trap_ret) begin
                npc = m_epc;
            end else if (redirect_valid) begin
                if (redirect_target % 4 != 0) begin
                    npc = TV; m_epc = m_pc; m_mis = 1;
                end else begin
                    npc = redirect_target;
                end
            end else if (!stall && fif.fetch_ready) begin
                npc = m_pc + 4;
            end
            if (fif.fetch_ready) m_cnt = m_cnt + 1;
            if (halt_req && !trap_valid) m_halt = 1;
            m_pc = npc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.pc",       fif.pc,                m_pc);
            chk("model.pc_plus4", fif.pc_plus4,          m_pc + 32'd4);
            chk("model.epc",      epc,                   m_epc);
            chk("model.mis",      {31'd0, misaligned},   {31'd0, m_mis});
            chk("model.halted",   {31'd0, halted},       {31'd0, m_halt});
            chk("model.valid",    {31'd0, fif.fetch_valid}, {31'd0, !m_halt});
            chk("model.cnt",      fetch_cnt,             m_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; redirect_valid = 0; redirect_target = 0; trap_valid = 0;
        trap_ret = 0; halt_req = 0; resume = 0;
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_valid = 1; redirect_target = t;
        tick(1);
        redirect_valid = 0;
    endtask

    initial begin
        clr = 0; idle(); fif.fetch_ready = 0;
        tick(2);
        clr = 1; chk_en = 1;
        chk("rst.pc", fif.pc, 32'h0);
        chk("rst.valid", {31'd0, fif.fetch_valid}, 32'd1);
        chk("rst.cnt", fetch_cnt, 32'd0);
        chk("rst.halted", {31'd0, halted}, 32'd0);

        fif.fetch_ready = 1;
        tick(1); chk("seq.pc1", fif.pc, 32'h4);
        tick(1); chk("seq.pc2", fif.pc, 32'h8);
        tick(1); chk("seq.pc3", fif.pc, 32'hC);
        fif.fetch_ready = 0;
        tick(2); chk("seq.hold", fif.pc, 32'hC);
        chk("seq.cnt", fetch_cnt, 32'd3);

        redir(32'h8);
        stall = 1; redir(32'h40); stall = 0;
        chk("redir.stall", fif.pc, 32'h40);
        redir(32'h8);
        redir(32'h42);
        chk("mis.pc", fif.pc, TV);
        chk("mis.epc", epc, 32'h8);
        chk("mis.pulse", {31'd0, misaligned}, 32'd1);
        tick(1);
        chk("mis.clear", {31'd0, misaligned}, 32'd0);

        redir(32'h20);
        trap_valid = 1; redirect_valid = 1; redirect_target = 32'h40;
        tick(1); idle();
        chk("trap.pc", fif.pc, TV);
        chk("trap.epc", epc, 32'h20);
        trap_ret = 1; tick(1); idle();
        chk("mret.pc", fif.pc, 32'h20);

        redir(32'h10);
        halt_req = 1; tick(1); idle();
        chk("halt.halted", {31'd0, halted}, 32'd1);
        chk("halt.valid", {31'd0, fif.fetch_valid}, 32'd0);
        fif.fetch_ready = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("halt.pc", fif.pc, 32'h10);
        end
        chk("halt.cnt", fetch_cnt, 32'd3);
        resume = 1; tick(1); idle();
        chk("resume.valid", {31'd0, fif.fetch_valid}, 32'd1);
        chk("resume.pc", fif.pc, 32'h10);
        chk("resume.cnt", fetch_cnt, 32'd3);
        tick(1);
        chk("resume.adv", fif.pc, 32'h14);
        chk("resume.cnt2", fetch_cnt, 32'd4);

        fif.fetch_ready = 0;
        redir(32'hFFFF_FFFC);
        chk("wrap.pc", fif.pc, 32'hFFFF_FFFC);
        chk("wrap.plus4", fif.pc_plus4, 32'h0);
        fif.fetch_ready = 1; tick(1); fif.fetch_ready = 0;
        chk("wrap.adv", fif.pc, 32'h0);
        chk("wrap.cnt", fetch_cnt, 32'd5);

        halt_req = 1; trap_valid = 1; tick(1); idle();
        chk("trhalt.pc", fif.pc, TV);
        chk("trhalt.run", {31'd0, halted}, 32'd0);
        halt_req = 1; tick(1); idle();
        chk("halt2", {31'd0, halted}, 32'd1);
        clr = 0; tick(1); clr = 1;
        chk("clr.pc", fif.pc, RV);
        chk("clr.halted", {31'd0, halted}, 32'd0);
        chk("clr.valid", {31'd0, fif.fetch_valid}, 32'd1);
        chk("clr.cnt", fetch_cnt, 32'd0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
